ex_mem_branch_stage: RTL and testbench

EX_MEM_BRANCH_STAGE -- requirements
Module: ex_mem_branch_stage

---
 rtl/ex_mem_branch_stage_if.sv | 65 ++++++
 rtl/ex_mem_branch_stage.sv | 159 +++++++++++++++
 tb/tb_ex_mem_branch_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_branch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_branch_stage_if
// Description : Bundles the EX-side instruction/control inputs and the
//               MEM-side registered outputs of the EX/MEM branch stage.
//               master : driver of the EX-side fields (execute stage / bench)
//               slave  : the EX/MEM branch stage itself
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mem_branch_stage_if;

  // EX-side inputs
  logic        ex_valid;
  logic [31:0] alu_result;
  logic        n;
  logic        z;
  logic        c;
  logic        v;
  logic        branch;
  logic        jump;
  logic [2:0]  funct3;
  logic [31:0] pc_target;
  logic [31:0] pc_plus4;
  logic [31:0] write_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_write;
  logic [1:0]  result_src;
  logic        stall;
  logic        flush;

  // Redirect and MEM-side outputs
  logic        pc_src;
  logic [31:0] pc_redirect;
  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_write_data;
  logic [31:0] mem_pc_plus4;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_write;
  logic [1:0]  mem_result_src;
  logic [15:0] br_count;
  logic [15:0] br_taken_count;

  modport master (
    output ex_valid, alu_result, n, z, c, v, branch, jump, funct3,
           pc_target, pc_plus4, write_data, rd, reg_write, mem_write,
           result_src, stall, flush,
    input  pc_src, pc_redirect, mem_valid, mem_alu_result, mem_write_data,
           mem_pc_plus4, mem_rd, mem_reg_write, mem_mem_write,
           mem_result_src, br_count, br_taken_count
  );

  modport slave (
    input  ex_valid, alu_result, n, z, c, v, branch, jump, funct3,
           pc_target, pc_plus4, write_data, rd, reg_write, mem_write,
           result_src, stall, flush,
    output pc_src, pc_redirect, mem_valid, mem_alu_result, mem_write_data,
           mem_pc_plus4, mem_rd, mem_reg_write, mem_mem_write,
           mem_result_src, br_count, br_taken_count
  );

endinterface : ex_mem_branch_stage_if
`default_nettype wire

// File: rtl/ex_mem_branch_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_branch_stage
// Description : Branch resolution for the EX stage plus the EX/MEM pipeline
//               register and two saturating branch performance counters.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous, active-low reset
//               bus  - ex_mem_branch_stage_if.slave
//                      inputs : ex_valid, alu_result, n/z/c/v, branch, jump,
//                               funct3, pc_target, pc_plus4, write_data, rd,
//                               reg_write, mem_write, result_src, stall, flush
//                      outputs: pc_src, pc_redirect, mem_* fields, br_count,
//                               br_taken_count
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_branch_stage (
  input  logic                        clk,
  input  logic                        rst,
  ex_mem_branch_stage_if.slave        bus
);

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  // --------------------------------------------------------------------------
  // Branch condition (flags come from A-B)
  // --------------------------------------------------------------------------
  logic w_taken;
  logic w_pc_src;
  logic w_count_en;

  always_comb begin
    w_taken = 1'b0;
    case (bus.funct3)
      3'b000:  w_taken = bus.z;                  // beq
      3'b001:  w_taken = ~bus.z;                 // bne
      3'b100:  w_taken = bus.n ^ bus.v;          // blt
      3'b101:  w_taken = ~(bus.n ^ bus.v);       // bge
      3'b110:  w_taken = ~bus.c;                 // bltu: borrow means A<B
      3'b111:  w_taken = bus.c;                  // bgeu
      default: w_taken = 1'b0;                   // 010/011 reserved
    endcase
  end

  // Redirect is forced low while reset is held so fetch never follows
  // a stale EX instruction out of reset. jump dominates the branch term.
  assign w_pc_src = rst & bus.ex_valid & ~bus.stall &
                    (bus.jump | (bus.branch & w_taken));

  assign bus.pc_src      = w_pc_src;
  assign bus.pc_redirect = w_pc_src ? bus.pc_target : 32'h0;

  // A control-flow instruction is counted only when it actually advances
  // into MEM; flush squashes it.
  assign w_count_en = bus.ex_valid & ~bus.stall & ~bus.flush &
                      (bus.branch | bus.jump);

  // --------------------------------------------------------------------------
  // EX/MEM register
  // --------------------------------------------------------------------------
  logic        mem_valid_d,      mem_valid_q;
  logic [31:0] mem_alu_result_d, mem_alu_result_q;
  logic [31:0] mem_write_data_d, mem_write_data_q;
  logic [31:0] mem_pc_plus4_d,   mem_pc_plus4_q;
  logic [4:0]  mem_rd_d,         mem_rd_q;
  logic        reg_write_d,      reg_write_q;
  logic        mem_write_d,      mem_write_q;
  logic [1:0]  mem_result_src_d, mem_result_src_q;
  logic [15:0] br_count_d,       br_count_q;
  logic [15:0] br_taken_count_d, br_taken_count_q;

  always_comb begin
    // hold by default; covers the stall case
    mem_valid_d      = mem_valid_q;
    mem_alu_result_d = mem_alu_result_q;
    mem_write_data_d = mem_write_data_q;
    mem_pc_plus4_d   = mem_pc_plus4_q;
    mem_rd_d         = mem_rd_q;
    reg_write_d      = reg_write_q;
    mem_write_d      = mem_write_q;
    mem_result_src_d = mem_result_src_q;

    if (bus.flush) begin
      // flush wins over stall: the slot becomes an all-zero bubble
      mem_valid_d      = 1'b0;
      mem_alu_result_d = 32'h0;
      mem_write_data_d = 32'h0;
      mem_pc_plus4_d   = 32'h0;
      mem_rd_d         = 5'h0;
      reg_write_d      = 1'b0;
      mem_write_d      = 1'b0;
      mem_result_src_d = 2'h0;
    end else if (!bus.stall) begin
      mem_valid_d      = bus.ex_valid;
      mem_alu_result_d = bus.alu_result;
      mem_write_data_d = bus.write_data;
      mem_pc_plus4_d   = bus.pc_plus4;
      mem_rd_d         = bus.rd;
      reg_write_d      = bus.reg_write;
      mem_write_d      = bus.mem_write;
      mem_result_src_d = bus.result_src;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters (independent of the EX/MEM hold)
  // --------------------------------------------------------------------------
  always_comb begin
    br_count_d       = br_count_q;
    br_taken_count_d = br_taken_count_q;
    if (w_count_en && (br_count_q != c_cnt_max)) begin
      br_count_d = br_count_q + 16'd1;
    end
    if (w_count_en && w_pc_src && (br_taken_count_q != c_cnt_max)) begin
      br_taken_count_d = br_taken_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid_q      <= 1'b0;
      mem_alu_result_q <= 32'h0;
      mem_write_data_q <= 32'h0;
      mem_pc_plus4_q   <= 32'h0;
      mem_rd_q         <= 5'h0;
      reg_write_q      <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_result_src_q <= 2'h0;
      br_count_q       <= 16'h0;
      br_taken_count_q <= 16'h0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_write_data_q <= mem_write_data_d;
      mem_pc_plus4_q   <= mem_pc_plus4_d;
      mem_rd_q         <= mem_rd_d;
      reg_write_q      <= reg_write_d;
      mem_write_q      <= mem_write_d;
      mem_result_src_q <= mem_result_src_d;
      br_count_q       <= br_count_d;
      br_taken_count_q <= br_taken_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs; write enables are qualified by valid so a bubble never writes
  // --------------------------------------------------------------------------
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_alu_result = mem_alu_result_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_pc_plus4   = mem_pc_plus4_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_reg_write  = reg_write_q & mem_valid_q;
  assign bus.mem_mem_write  = mem_write_q & mem_valid_q;
  assign bus.mem_result_src = mem_result_src_q;
  assign bus.br_count       = br_count_q;
  assign bus.br_taken_count = br_taken_count_q;

endmodule : ex_mem_branch_stage
`default_nettype wire

// File: tb/tb_ex_mem_branch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_branch_stage
// Description : Directed self-checking bench for ex_mem_branch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_branch_stage;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  ex_mem_branch_stage_if bus ();

  ex_mem_branch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample point is 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ex_valid   = 1'b0;
    bus.alu_result = 32'h0;
    bus.n = 1'b0; bus.z = 1'b0; bus.c = 1'b0; bus.v = 1'b0;
    bus.branch     = 1'b0;
    bus.jump       = 1'b0;
    bus.funct3     = 3'b000;
    bus.pc_target  = 32'h0;
    bus.pc_plus4   = 32'h0;
    bus.write_data = 32'h0;
    bus.rd         = 5'h0;
    bus.reg_write  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.result_src = 2'h0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;

    // ---------------- reset state; redirect suppressed in reset ----------
    bus.ex_valid  = 1'b1;
    bus.jump      = 1'b1;
    bus.pc_target = 32'h300;
    #1;
    check_val("rst_pc_src",      32'(bus.pc_src), 32'h0);
    check_val("rst_pc_redirect", bus.pc_redirect, 32'h0);
    tick();
    check_val("rst_mem_valid",   32'(bus.mem_valid), 32'h0);
    check_val("rst_br_count",    32'(bus.br_count), 32'h0);
    check_val("rst_taken_count", 32'(bus.br_taken_count), 32'h0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // ---------------- beq taken ------------------------------------------
    bus.ex_valid   = 1'b1;
    bus.branch     = 1'b1;
    bus.funct3     = 3'b000;
    bus.z          = 1'b1;
    bus.pc_target  = 32'h100;
    bus.alu_result = 32'h1111_1111;
    bus.pc_plus4   = 32'h0000_0044;
    #1;
    check_val("beq_pc_src",   32'(bus.pc_src), 32'h1);
    check_val("beq_redirect", bus.pc_redirect, 32'h100);
    tick();
    check_val("beq_br_count",   32'(bus.br_count), 32'd1);
    check_val("beq_taken_cnt",  32'(bus.br_taken_count), 32'd1);
    check_val("beq_mem_valid",  32'(bus.mem_valid), 32'h1);
    check_val("beq_mem_alu",    bus.mem_alu_result, 32'h1111_1111);
    check_val("beq_mem_pc4",    bus.mem_pc_plus4, 32'h0000_0044);

    // ---------------- blt signed taken ------------------------------------
    bus.z = 1'b0; bus.n = 1'b0; bus.v = 1'b1;
    bus.funct3 = 3'b100;
    #1;
    check_val("blt_pc_src", 32'(bus.pc_src), 32'h1);
    tick();

    // ---------------- bltu not taken (c=1 means no borrow) ---------------
    bus.n = 1'b0; bus.v = 1'b0; bus.c = 1'b1;
    bus.funct3 = 3'b110;
    #1;
    check_val("bltu_pc_src",   32'(bus.pc_src), 32'h0);
    check_val("bltu_redirect", bus.pc_redirect, 32'h0);
    tick();

    // ---------------- bne with z=1 not taken ------------------------------
    bus.c = 1'b0; bus.z = 1'b1;
    bus.funct3 = 3'b001;
    #1;
    check_val("bne_pc_src", 32'(bus.pc_src), 32'h0);
    tick();
    check_val("br_count_4",  32'(bus.br_count), 32'd4);
    check_val("taken_cnt_2", 32'(bus.br_taken_count), 32'd2);

    // ---------------- jump overrides a never-taken funct3 ----------------
    bus.jump      = 1'b1;
    bus.funct3    = 3'b010;
    bus.z         = 1'b0;
    bus.pc_target = 32'h200;
    #1;
    check_val("jmp_pc_src",   32'(bus.pc_src), 32'h1);
    check_val("jmp_redirect", bus.pc_redirect, 32'h200);
    tick();
    check_val("jmp_br_count",  32'(bus.br_count), 32'd5);
    check_val("jmp_taken_cnt", 32'(bus.br_taken_count), 32'd3);

    // ---------------- load entry for stall test ---------------------------
    clear_inputs();
    bus.ex_valid   = 1'b1;
    bus.alu_result = 32'hDEAD_BEEF;
    bus.rd         = 5'd5;
    bus.reg_write  = 1'b1;
    bus.write_data = 32'h0000_CAFE;
    bus.result_src = 2'd1;
    tick();
    check_val("ld_mem_alu",   bus.mem_alu_result, 32'hDEAD_BEEF);
    check_val("ld_mem_rd",    32'(bus.mem_rd), 32'd5);
    check_val("ld_mem_rw",    32'(bus.mem_reg_write), 32'h1);
    check_val("ld_mem_wdata", bus.mem_write_data, 32'h0000_CAFE);
    check_val("ld_mem_rsrc",  32'(bus.mem_result_src), 32'd1);

    // ---------------- stall for 3 cycles with changing inputs ------------
    bus.stall = 1'b1;
    bus.jump  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alu_result = 32'h1234_5600 + 32'(i);
      bus.rd         = 5'd9 + 5'(i);
      #1;
      check_val("stall_pc_src", 32'(bus.pc_src), 32'h0);
      tick();
      check_val("stall_mem_alu", bus.mem_alu_result, 32'hDEAD_BEEF);
      check_val("stall_mem_rd",  32'(bus.mem_rd), 32'd5);
    end
    check_val("stall_br_count", 32'(bus.br_count), 32'd5);

    // ---------------- stall + flush together: flush wins -----------------
    bus.flush = 1'b1;
    tick();
    check_val("flush_mem_valid", 32'(bus.mem_valid), 32'h0);
    check_val("flush_mem_rw",    32'(bus.mem_reg_write), 32'h0);
    check_val("flush_mem_alu",   bus.mem_alu_result, 32'h0);
    check_val("flush_mem_rd",    32'(bus.mem_rd), 32'h0);

    // ---------------- bubble gating ---------------------------------------
    clear_inputs();
    bus.ex_valid  = 1'b0;
    bus.reg_write = 1'b1;
    bus.mem_write = 1'b1;
    bus.jump      = 1'b1;
    bus.pc_target = 32'h400;
    #1;
    check_val("bub_pc_src",   32'(bus.pc_src), 32'h0);
    check_val("bub_redirect", bus.pc_redirect, 32'h0);
    tick();
    check_val("bub_mem_rw", 32'(bus.mem_reg_write), 32'h0);
    check_val("bub_mem_mw", 32'(bus.mem_mem_write), 32'h0);
    check_val("bub_br_cnt", 32'(bus.br_count), 32'd5);

    // valid store reaches MEM with its write enable
    bus.ex_valid  = 1'b1;
    bus.reg_write = 1'b0;
    bus.jump      = 1'b0;
    tick();
    check_val("st_mem_mw", 32'(bus.mem_mem_write), 32'h1);
    check_val("st_mem_rw", 32'(bus.mem_reg_write), 32'h0);

    // flushed jump still redirects but is not counted
    bus.mem_write = 1'b0;
    bus.jump      = 1'b1;
    bus.flush     = 1'b1;
    #1;
    check_val("fj_pc_src", 32'(bus.pc_src), 32'h1);
    tick();
    check_val("fj_br_cnt",  32'(bus.br_count), 32'd5);
    check_val("fj_tk_cnt",  32'(bus.br_taken_count), 32'd3);

    // ---------------- async reset mid-stall -------------------------------
    clear_inputs();
    bus.ex_valid   = 1'b1;
    bus.alu_result = 32'h0000_A5A5;
    tick();
    check_val("pre_rst_valid", 32'(bus.mem_valid), 32'h1);
    bus.stall = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_mem_valid", 32'(bus.mem_valid), 32'h0);
    check_val("arst_mem_alu",   bus.mem_alu_result, 32'h0);
    check_val("arst_br_count",  32'(bus.br_count), 32'h0);
    check_val("arst_tk_count",  32'(bus.br_taken_count), 32'h0);
    bus.stall      = 1'b0;
    bus.alu_result = 32'h0000_0077;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_val("post_rst_alu",   bus.mem_alu_result, 32'h0000_0077);
    check_val("post_rst_valid", 32'(bus.mem_valid), 32'h1);

    // ---------------- counter saturation ----------------------------------
    bus.jump      = 1'b1;
    bus.pc_target = 32'h500;
    repeat (16'hFFFE) @(posedge clk);
    #1;
    check_val("sat_pre_br", 32'(bus.br_count), 32'h0000_FFFE);
    check_val("sat_pre_tk", 32'(bus.br_taken_count), 32'h0000_FFFE);
    repeat (3) @(posedge clk);
    #1;
    check_val("sat_br", 32'(bus.br_count), 32'h0000_FFFF);
    check_val("sat_tk", 32'(bus.br_taken_count), 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_ex_mem_branch_stage
`default_nettype wire
